// File: rtl/cpu_dma_engine.sv
// rtl/cpu_dma_engine.sv - multi-channel halting block-copy DMA engine for the 2A03 system bus
module cpu_dma_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 2,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [1:0]                                       cfg_reg,
  input  logic [ADDR_WIDTH-1:0]                            cfg_wdata,
  input  logic                                             cpu_rw,
  output logic                                             halt,
  output logic                                             dma_active,
  output logic [ADDR_WIDTH-1:0]                            dma_addr,
  output logic                                             dma_rw,
  output logic [DATA_WIDTH-1:0]                            dma_data_out,
  input  logic [DATA_WIDTH-1:0]                            data_in,
  output logic [CHANNELS-1:0]                              busy,
  output logic [CHANNELS-1:0]                              done
);

  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_WIDTH:0]    REM_ONE  = 1;
  localparam logic [LEN_WIDTH:0]    REM_FULL = {1'b1, {LEN_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t state, state_next;
  logic   parity;

  logic [ADDR_WIDTH-1:0] src_reg [CHANNELS];
  logic [ADDR_WIDTH-1:0] dst_reg [CHANNELS];
  logic [LEN_WIDTH-1:0]  len_reg [CHANNELS];
  logic [CHANNELS-1:0]   inc_reg;
  logic [CHANNELS-1:0]   busy_q;

  logic [CHAN_W-1:0]     sel_chan;
  logic [CHAN_W-1:0]     cur_chan;
  logic [ADDR_WIDTH-1:0] cur_src;
  logic [ADDR_WIDTH-1:0] cur_dst;
  logic [LEN_WIDTH:0]    remaining;
  logic                  cur_inc;
  logic [DATA_WIDTH-1:0] wbuf;
  logic                  last_write;
  logic                  cfg_hit;

  assign busy       = busy_q;
  assign last_write = (state == S_WRITE) && (remaining == REM_ONE);
  // A busy channel is locked against every register write, CTRL included
  assign cfg_hit    = cfg_we && (int'(cfg_chan) < CHANNELS) && !busy_q[cfg_chan];

  // Lowest-indexed pending channel wins arbitration
  always_comb begin
    sel_chan = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (busy_q[i]) sel_chan = CHAN_W'(i);
    end
  end

  // FSM state register and free-running GET/PUT parity
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      parity <= 1'b0;
    end else begin
      state  <= state_next;
      parity <= ~parity;
    end
  end

  // Next-state and bus outputs
  always_comb begin
    state_next   = state;
    halt         = 1'b0;
    dma_active   = 1'b0;
    dma_rw       = 1'b1;
    dma_addr     = '0;
    dma_data_out = '0;
    done         = '0;
    case (state)
      S_IDLE: begin
        if (busy_q != '0) state_next = S_HALT_WAIT;
      end
      S_HALT_WAIT: begin
        halt = 1'b1;
        // the core only stops on a read cycle
        if (cpu_rw) state_next = S_ALIGN;
      end
      S_ALIGN: begin
        halt = 1'b1;
        // leave only when the following cycle is a GET cycle
        if (parity) state_next = S_READ;
      end
      S_READ: begin
        halt       = 1'b1;
        dma_active = 1'b1;
        dma_addr   = cur_src;
        state_next = S_WRITE;
      end
      S_WRITE: begin
        halt         = 1'b1;
        dma_active   = 1'b1;
        dma_rw       = 1'b0;
        dma_addr     = cur_dst;
        dma_data_out = wbuf;
        if (last_write) begin
          done[cur_chan] = 1'b1;
          state_next     = S_IDLE;
        end else begin
          state_next = S_READ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Per-channel configuration registers and pending flags
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        src_reg[i] <= '0;
        dst_reg[i] <= '0;
        len_reg[i] <= '0;
      end
      inc_reg <= '0;
      busy_q  <= '0;
    end else begin
      // cfg_hit never targets cur_chan, so the clear and a new start cannot collide
      if (last_write) busy_q[cur_chan] <= 1'b0;
      if (cfg_hit) begin
        case (cfg_reg)
          2'd0: src_reg[cfg_chan] <= cfg_wdata;
          2'd1: dst_reg[cfg_chan] <= cfg_wdata;
          2'd2: len_reg[cfg_chan] <= cfg_wdata[LEN_WIDTH-1:0];
          2'd3: begin
            inc_reg[cfg_chan] <= cfg_wdata[1];
            if (cfg_wdata[0]) busy_q[cfg_chan] <= 1'b1;
          end
        endcase
      end
    end
  end

  // Working counters of the channel currently being served
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_chan  <= '0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      cur_inc   <= 1'b0;
      wbuf      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (busy_q != '0) begin
            cur_chan  <= sel_chan;
            cur_src   <= src_reg[sel_chan];
            cur_dst   <= dst_reg[sel_chan];
            cur_inc   <= inc_reg[sel_chan];
            remaining <= (len_reg[sel_chan] == '0) ? REM_FULL : {1'b0, len_reg[sel_chan]};
          end
        end
        S_READ: begin
          wbuf    <= data_in;
          cur_src <= cur_src + ADDR_ONE;
        end
        S_WRITE: begin
          if (cur_inc) cur_dst <= cur_dst + ADDR_ONE;
          remaining <= remaining - REM_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_dma_engine.sv
// tb/tb_cpu_dma_engine.sv - self-checking bench for cpu_dma_engine against a transfer-level model
module tb_cpu_dma_engine;

  localparam int CH = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_chan;
  logic [1:0]  cfg_reg;
  logic [15:0] cfg_wdata;
  logic        cpu_rw;
  logic        halt;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_data_out;
  logic [7:0]  data_in;
  logic [CH-1:0] busy;
  logic [CH-1:0] done;

  cpu_dma_engine #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .CHANNELS(CH), .LEN_WIDTH(8)
  ) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_reg(cfg_reg), .cfg_wdata(cfg_wdata), .cpu_rw(cpu_rw), .halt(halt),
    .dma_active(dma_active), .dma_addr(dma_addr), .dma_rw(dma_rw),
    .dma_data_out(dma_data_out), .data_in(data_in), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:65535];
  assign data_in = mem[dma_addr];

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        par;
  } op_t;

  op_t obs_q[$];
  op_t exp_q[$];
  int  low_q[$];
  int  rise_q[$];
  int  pre_q[$];
  int  zero_q[$];
  int  done_cnt [CH];
  int  low_run, pre_cnt, zeros;
  bit  seen_active, prev_halt;
  logic [31:0] pcount;
  int  checks, errors;

  // cycle parity as the spec defines it: 0 on the first cycle after reset
  always @(posedge clock) begin
    if (reset) pcount <= 0;
    else       pcount <= pcount + 1;
  end

  // bus monitor: logs DMA bus ops, halt episodes and done pulses
  always @(negedge clock) begin
    if (reset) begin
      prev_halt   = 1'b0;
      seen_active = 1'b1;
      low_run     = 0;
    end else begin
      if (halt && !prev_halt) begin
        low_q.push_back(low_run);
        rise_q.push_back(int'(pcount[0]));
        pre_cnt     = 0;
        zeros       = 0;
        seen_active = 1'b0;
        low_run     = 0;
      end
      if (!halt) low_run++;
      if (halt && !dma_active && !seen_active) begin
        pre_cnt++;
        if (!cpu_rw) zeros++;
      end
      if (dma_active) begin
        obs_q.push_back('{rw: dma_rw, addr: dma_addr, data: dma_data_out, par: pcount[0]});
        if (!seen_active) begin
          pre_q.push_back(pre_cnt);
          zero_q.push_back(zeros);
          seen_active = 1'b1;
        end
      end
      for (int c = 0; c < CH; c++) done_cnt[c] += int'(done[c]);
      prev_halt = halt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg(input int ch, input int r, input logic [15:0] d);
    cfg_we    = 1'b1;
    cfg_chan  = 2'(ch);
    cfg_reg   = 2'(r);
    cfg_wdata = d;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic setup(input int ch, input logic [15:0] s, input logic [15:0] d, input int len);
    cfg(ch, 0, s);
    cfg(ch, 1, d);
    cfg(ch, 2, 16'(len));
  endtask

  task automatic start(input int ch, input logic inc);
    cfg(ch, 3, {14'd0, inc, 1'b1});
  endtask

  // one transfer = N (read src+i, write dst[+i] with that byte), reads on parity 0
  task automatic expect_xfer(input logic [15:0] s, input logic [15:0] d, input int len, input logic inc);
    int n;
    op_t o;
    logic [15:0] a;
    n = (len == 0) ? 256 : len;
    for (int i = 0; i < n; i++) begin
      a = s + 16'(i);
      o.rw = 1'b1; o.addr = a; o.data = 8'h00; o.par = 1'b0;
      exp_q.push_back(o);
      o.rw = 1'b0; o.addr = inc ? d + 16'(i) : d; o.data = mem[a]; o.par = 1'b1;
      exp_q.push_back(o);
    end
  endtask

  task automatic compare_ops(input string tag, input int base);
    int nmis;
    op_t o, e;
    nmis = 0;
    check({tag, " op count"}, 32'(obs_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      o = obs_q[base + i];
      e = exp_q[i];
      if (o.rw !== e.rw || o.addr !== e.addr || o.par !== e.par || (!e.rw && o.data !== e.data))
        nmis++;
    end
    check({tag, " op mismatches"}, 32'(nmis), 0);
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy !== '0 || halt !== 1'b0) && n < budget) begin
      step();
      n++;
    end
    check({tag, " completes"}, 32'(n < budget), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rbase, pbase, zbase, d0, d1, d2, n, wr, ch, len, l0, l1;
    int align_obs [2];
    int align_exp, zo, pre;
    logic [15:0] s, d, s0, s1, s2, d_0, d_1, d_2;
    logic inc;
    op_t last_rd;

    checks = 0;
    errors = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    reset = 1'b1; cfg_we = 1'b0; cfg_chan = '0; cfg_reg = '0; cfg_wdata = '0; cpu_rw = 1'b1;
    step(); step(); step();

    // reset state
    check("rst halt", 32'(halt), 0);
    check("rst dma_active", 32'(dma_active), 0);
    check("rst dma_rw", 32'(dma_rw), 1);
    check("rst dma_addr", 32'(dma_addr), 0);
    check("rst dma_data_out", 32'(dma_data_out), 0);
    check("rst done", 32'(done), 0);
    check("rst busy", 32'(busy), 0);
    reset = 1'b0;
    step();

    // fixed destination OAM-style copy
    base = obs_q.size(); d0 = done_cnt[0];
    setup(0, 16'h0200, 16'h2004, 4);
    start(0, 1'b0);
    wait_idle("t1", 200);
    expect_xfer(16'h0200, 16'h2004, 4, 1'b0);
    compare_ops("t1", base);
    check("t1 done0 pulses", 32'(done_cnt[0] - d0), 1);
    check("t1 busy", 32'(busy), 0);

    // LEN=0 means 256 transfers
    base = obs_q.size();
    setup(0, 16'h0200, 16'h2004, 0);
    start(0, 1'b0);
    wait_idle("t2", 1500);
    expect_xfer(16'h0200, 16'h2004, 0, 1'b0);
    compare_ops("t2", base);
    last_rd = (obs_q.size() >= base + 2) ? obs_q[obs_q.size() - 2] : '0;
    check("t2 src end", 32'(last_rd.addr + 16'd1), 32'h0300);

    // core stuck on writes, then alignment on both parities
    for (int ph = 0; ph < 2; ph++) begin
      s = 16'($urandom); len = $urandom_range(2, 5);
      setup(0, s, 16'h2004, len);
      cpu_rw = 1'b0;
      if (pcount[0] !== 1'(ph)) step();
      base = obs_q.size(); rbase = rise_q.size(); pbase = pre_q.size(); zbase = zero_q.size();
      start(0, 1'b0);
      repeat (4) step();
      cpu_rw = 1'b1;
      wait_idle("t3", 200);
      expect_xfer(s, 16'h2004, len, 1'b0);
      compare_ops("t3", base);
      zo  = zero_q[zbase];
      pre = pre_q[pbase];
      check("t3 halted write cycles", 32'(zo), 3);
      align_exp = (((rise_q[rbase] + zo + 1) % 2) == 1) ? 1 : 2;
      check("t3 pre-transfer halt length", 32'(pre), 32'(zo + 1 + align_exp));
      align_obs[ph] = pre - zo - 1;
    end
    check("t3 align on phase 0", 32'(align_obs[0]), 2);
    check("t3 align on phase 1", 32'(align_obs[1]), 1);

    // address wrap with incrementing destination
    base = obs_q.size();
    setup(0, 16'hFFFE, 16'h0010, 3);
    start(0, 1'b1);
    wait_idle("t4", 200);
    expect_xfer(16'hFFFE, 16'h0010, 3, 1'b1);
    compare_ops("t4", base);

    // randomized single transfers
    for (int k = 0; k < 4; k++) begin
      ch = $urandom_range(0, CH - 1);
      s = 16'($urandom); d = 16'($urandom); len = $urandom_range(1, 12); inc = 1'($urandom);
      cpu_rw = 1'b1;
      base = obs_q.size(); d0 = done_cnt[ch];
      setup(ch, s, d, len);
      start(ch, inc);
      wait_idle("rand", 300);
      expect_xfer(s, d, len, inc);
      compare_ops("rand", base);
      check("rand done pulses", 32'(done_cnt[ch] - d0), 1);
    end

    // queued starts while busy: priority order and mandatory gap
    s2 = 16'($urandom); d_2 = 16'($urandom); s1 = 16'($urandom); d_1 = 16'($urandom);
    s0 = 16'($urandom); d_0 = 16'($urandom); l0 = $urandom_range(1, 6); l1 = $urandom_range(1, 6);
    base = obs_q.size(); rbase = low_q.size();
    d0 = done_cnt[0]; d1 = done_cnt[1]; d2 = done_cnt[2];
    setup(2, s2, d_2, 8);
    start(2, 1'b1);
    setup(1, s1, d_1, l1);
    start(1, 1'b0);
    setup(0, s0, d_0, l0);
    start(0, 1'b1);
    cfg(0, 0, 16'hDEAD);
    wait_idle("t5", 400);
    expect_xfer(s2, d_2, 8, 1'b1);
    expect_xfer(s0, d_0, l0, 1'b1);
    expect_xfer(s1, d_1, l1, 1'b0);
    compare_ops("t5", base);
    check("t5 gap before ch0", 32'(low_q[rbase + 1]), 1);
    check("t5 gap before ch1", 32'(low_q[rbase + 2]), 1);
    check("t5 done pulses", 32'((done_cnt[0] - d0) + (done_cnt[1] - d1) + (done_cnt[2] - d2)), 3);

    // start on ch1 in the same cycle ch0 finishes
    s0 = 16'($urandom); s1 = 16'($urandom); l0 = $urandom_range(1, 5); l1 = $urandom_range(1, 5);
    base = obs_q.size(); rbase = low_q.size(); d1 = done_cnt[1];
    setup(1, s1, 16'h4000, l1);
    setup(0, s0, 16'h2004, l0);
    start(0, 1'b0);
    n = 0;
    while (done[0] !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("t5b ch0 done seen", 32'(n < 100), 1);
    start(1, 1'b1);
    wait_idle("t5b", 300);
    expect_xfer(s0, 16'h2004, l0, 1'b0);
    expect_xfer(s1, 16'h4000, l1, 1'b1);
    compare_ops("t5b", base);
    check("t5b gap before ch1", 32'(low_q[rbase + 1]), 1);
    check("t5b ch1 done pulses", 32'(done_cnt[1] - d1), 1);

    // reset during the second write abandons the transfer
    d0 = done_cnt[0];
    setup(0, 16'h0300, 16'h2004, 5);
    start(0, 1'b0);
    n = 0; wr = 0;
    while (wr < 2 && n < 100) begin
      step();
      n++;
      if (dma_active === 1'b1 && dma_rw === 1'b0) wr++;
    end
    check("t6 second write reached", 32'(wr), 2);
    reset = 1'b1;
    step();
    check("t6 halt after reset", 32'(halt), 0);
    check("t6 dma_active after reset", 32'(dma_active), 0);
    check("t6 busy after reset", 32'(busy), 0);
    reset = 1'b0;
    repeat (5) step();
    check("t6 no restart", 32'(halt), 0);
    check("t6 no done pulse", 32'(done_cnt[0] - d0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_dma_engine.md
Name: cpu_dma_engine

Overview:
- Parametrised, multi-channel successor to the 2A03's single-purpose sprite DMA.
- Halts the 6502 core, takes the system bus, and copies blocks from a source address to a destination address. The destination can be fixed (e.g. $2004 OAMDATA) or incrementing.
- Sits beside cpu_2a03. A top-level mux selects the DMA address, data and rw whenever dma_active is high.

Parameters:
- ADDR_WIDTH, 16, width of the system address bus and of the src/dst registers.
- DATA_WIDTH, 8, width of the data bus.
- CHANNELS, 2, number of independent channels (1..8).
- LEN_WIDTH, 8, width of the length register. A value of 0 encodes 2^LEN_WIDTH transfers.

Ports:
- clock  in  1  system clock (CPU rate).
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe, one cycle per write.
- cfg_chan  in  $clog2(CHANNELS) (min 1)  channel selected for the write.
- cfg_reg  in  2  register select: 0=SRC, 1=DST, 2=LEN, 3=CTRL.
- cfg_wdata  in  ADDR_WIDTH  write data. CTRL uses bit0=start, bit1=dst_inc.
- cpu_rw  in  1  rw output of the core for the current cycle (1=read).
- halt  out  1  stall request to the core.
- dma_active  out  1  DMA owns the bus this cycle.
- dma_addr  out  ADDR_WIDTH  bus address while active.
- dma_rw  out  1  bus direction while active (1=read, 0=write).
- dma_data_out  out  DATA_WIDTH  write data while active.
- data_in  in  DATA_WIDTH  system read data.
- busy  out  CHANNELS  per-channel pending-or-running flag.
- done  out  CHANNELS  one-cycle pulse when a channel completes.

Behaviour:
- Reset:
  - state=IDLE; all SRC/DST/LEN/dst_inc registers and busy are 0.
  - halt=0, dma_active=0, dma_rw=1, dma_addr=0, dma_data_out=0, done=0.
  - parity flop=0.
- Parity: a free-running flop toggles every clock after reset. A cycle with parity=0 is a GET cycle; parity=1 is a PUT cycle.
- Config writes:
  - SRC, DST and LEN write the low bits of cfg_wdata into the selected channel's register.
  - A CTRL write latches dst_inc. If start=1, it also sets busy[chan].
  - Any write to a channel whose busy bit is set is ignored entirely. This includes CTRL, so a restart cannot occur mid-transfer.
- Arbitration: in IDLE, the lowest-indexed busy channel is selected. Its registers are copied into working counters: cur_src, cur_dst, remaining (LEN=0 loads 2^LEN_WIDTH).
- FSM states and transitions:
  - IDLE -> HALT_WAIT when any busy bit is set; halt=1 from that cycle.
  - HALT_WAIT: the core cannot stop on a write. Stay while cpu_rw=0; go to ALIGN on the first cycle where cpu_rw=1.
  - ALIGN: one dummy cycle with dma_active=0 and halt=1. Go to READ only if the next cycle is a GET cycle; otherwise stay one more cycle. Total alignment is 1 or 2 cycles.
  - READ (always a GET cycle):
    - dma_active=1, dma_rw=1, dma_addr=cur_src.
    - data_in is latched at the clock edge into the write buffer.
    - cur_src increments, wrapping mod 2^ADDR_WIDTH.
    - Next state is WRITE.
  - WRITE (PUT cycle):
    - dma_active=1, dma_rw=0, dma_addr=cur_dst, dma_data_out=write buffer.
    - cur_dst increments only if dst_inc=1, wrapping.
    - remaining decrements.
    - If remaining was 1: clear busy, pulse done for one cycle, go to IDLE.
    - Otherwise go to READ.
- halt stays high from HALT_WAIT through the final WRITE and drops in the cycle after it.
- No back-to-back chaining: IDLE always spends at least one cycle with halt=0 before the next channel is served, so the core gets at least one cycle between channels.
- Cycle cost per transfer: 1 (IDLE detect) + HALT_WAIT cycles + 1 or 2 (ALIGN) + 2*N.
- Simultaneous start: a start on channel k in the same cycle that channel j<k finishes is honoured. Channel k is served after the mandatory IDLE cycle.
- Reset mid-transfer: halt and dma_active deassert on the next edge, the transfer is abandoned, and done does not pulse.

Test Plan:
1. SRC=$0200, DST=$2004, LEN=4, CTRL=1 (dst_inc=0) on ch0, with cpu_rw=1 throughout -> reads $0200..$0203, all four writes to $2004 carry the read data in order, one done[0] pulse, busy[0] clears.
2. Same setup with LEN=0, LEN_WIDTH=8 -> exactly 256 READ/WRITE pairs; source ends at $0300.
3. Start while cpu_rw=0 for 3 cycles -> halt held, dma_active stays 0 until cpu_rw=1; the first READ lands on a parity=0 cycle. Repeat with the start shifted by one cycle -> the ALIGN length changes between 1 and 2.
4. SRC=$FFFE, DST=$0010, dst_inc=1, LEN=3 -> reads $FFFE, $FFFF, $0000; writes $0010, $0011, $0012.
5. Start ch1 then ch0 in the same cycle -> ch0 runs first, halt drops for at least one cycle, then ch1 runs. A SRC write to ch0 during its transfer leaves cur_src unaffected.
6. Assert reset during the second WRITE -> halt=0 and dma_active=0 on the next cycle, busy=0, no done pulse.
